// File: rtl/kb_pkg.sv
// Shared constants, event layout and FSM encoding for the PS/2 set-2 key event decoder.
package kb_pkg;

   localparam logic [7:0] PFX_EXT = 8'hE0;
   localparam logic [7:0] PFX_BRK = 8'hF0;

   localparam int EV_W   = 10;
   localparam int EV_EXT = 9;
   localparam int EV_BRK = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_EXT     = 2'b01,
      ST_BRK     = 2'b10,
      ST_EXT_BRK = 2'b11
   } kb_state_e;

   // Keyboard control/status bytes that never form part of a key event
   function automatic logic is_ctrl(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ctrl = 1'b1;
         default:                                                 is_ctrl = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// First-word-fall-through event FIFO with registered full/empty flags and an overflow pulse.
module kb_event_fifo #(
   parameter int ADDR_W = 2,
   parameter int DW     = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head,
   output logic          empty,
   output logic          full,
   output logic          overflow_tick
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DW-1:0]     mem_q [DEPTH];
   logic [DW-1:0]     mem_d [DEPTH];
   logic [ADDR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic              empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
   logic              wr_ok_s, rd_ok_s;
   logic [ADDR_W-1:0] wr_nxt_s, rd_nxt_s;

   // A full FIFO still accepts a push when the same cycle frees a slot
   assign rd_ok_s  = pop & ~empty_q;
   assign wr_ok_s  = push & (~full_q | rd_ok_s);
   assign wr_nxt_s = wr_q + ADDR_W'(1);
   assign rd_nxt_s = rd_q + ADDR_W'(1);

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      empty_d = empty_q;
      full_d  = full_q;
      ovf_d   = push & ~wr_ok_s;
      if (wr_ok_s) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_nxt_s;
      end else begin
         wr_d = wr_q;
      end
      if (rd_ok_s) begin
         rd_d = rd_nxt_s;
      end else begin
         rd_d = rd_q;
      end
      case ({wr_ok_s, rd_ok_s})
         2'b10: begin
            empty_d = 1'b0;
            full_d  = (wr_nxt_s == rd_q);
         end
         2'b01: begin
            full_d  = 1'b0;
            empty_d = (rd_nxt_s == wr_q);
         end
         default: begin
            empty_d = empty_q;
            full_d  = full_q;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
      end
   end

   assign head          = mem_q[rd_q];
   assign empty         = empty_q;
   assign full          = full_q;
   assign overflow_tick = ovf_q;

endmodule

// File: rtl/kb_event_decoder.sv
// Folds PS/2 set-2 E0/F0 prefixes into {ext, brk, code} events, drops control bytes,
// aborts stale prefixes on timeout and queues completed events in a FWFT FIFO.
module kb_event_decoder
   import kb_pkg::*;
#(
   parameter int ADDR_W         = 2,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int CNT_W          = 17
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_done_tick,
   input  logic [7:0]      rx_data,
   input  logic            rd_event,
   output logic [EV_W-1:0] event_data,
   output logic            event_empty,
   output logic            event_full,
   output logic            overflow_tick,
   output logic            err_tick
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   kb_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             byte_v_s, expire_s, ext_s, brk_s, push_s;
   logic [EV_W-1:0]  push_data_s;

   assign byte_v_s = rx_done_tick & ~is_ctrl(rx_data);
   // A real byte on the expiry cycle takes priority over the timeout
   assign expire_s = (state_q != ST_IDLE) && (cnt_q == CNT_LAST) && !byte_v_s;

   always_comb begin
      ext_s = 1'b0;
      brk_s = 1'b0;
      case (state_q)
         ST_EXT:     ext_s = 1'b1;
         ST_BRK:     brk_s = 1'b1;
         ST_EXT_BRK: begin
            ext_s = 1'b1;
            brk_s = 1'b1;
         end
         default: begin
            ext_s = 1'b0;
            brk_s = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      err_d       = 1'b0;
      push_s      = 1'b0;
      push_data_s = {ext_s, brk_s, rx_data};
      if (byte_v_s) begin
         if (rx_data == PFX_EXT) begin
            state_d = brk_s ? ST_EXT_BRK : ST_EXT;
         end else if (rx_data == PFX_BRK) begin
            state_d = ext_s ? ST_EXT_BRK : ST_BRK;
         end else begin
            push_s  = 1'b1;
            state_d = ST_IDLE;
         end
      end else if (expire_s) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
      end else begin
         state_d = state_q;
      end
   end

   always_comb begin
      if ((state_q == ST_IDLE) || byte_v_s || expire_s) begin
         cnt_d = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign err_tick = err_q;

   kb_event_fifo #(
      .ADDR_W (ADDR_W),
      .DW     (EV_W)
   ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .push          (push_s),
      .push_data     (push_data_s),
      .pop           (rd_event),
      .head          (event_data),
      .empty         (event_empty),
      .full          (event_full),
      .overflow_tick (overflow_tick)
   );

endmodule
